// File: rtl/status_word_serializer.sv
// Streams a 35-bit status word LSB-first on a single wire, followed by an even-parity bit.
// A start/busy/done handshake frames each transfer; every output is registered.
module status_word_serializer #(
    parameter int BIT_DIV = 4
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic [34:0] mem_din,
    output logic        ser_out,
    output logic        ser_frame,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST  = 8'(BIT_DIV - 1);
    localparam logic [5:0] DATA_LAST = 6'd34;
    localparam logic [5:0] PAR_BIT   = 6'd35;

    function automatic logic parity_even(input logic [34:0] word);
        return ^word;
    endfunction

    state_t      state_r;
    logic [33:0] shift_r;
    logic        parity_r;
    logic [5:0]  bit_cnt_r;
    logic [7:0]  div_cnt_r;
    logic        bit_end_s;

    // The last divider count closes the current bit; BIT_DIV=1 makes every cycle a bit end.
    assign bit_end_s = (div_cnt_r == DIV_LAST);

    // Frame sequencer: bit 0 goes straight out at accept, so the shifter keeps only bits 34..1.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r   <= IDLE;
            shift_r   <= 34'd0;
            parity_r  <= 1'b0;
            bit_cnt_r <= 6'd0;
            div_cnt_r <= 8'd0;
            ser_out   <= 1'b1;
            ser_frame <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        shift_r   <= mem_din[34:1];
                        parity_r  <= parity_even(mem_din);
                        ser_out   <= mem_din[0];
                        bit_cnt_r <= 6'd0;
                        div_cnt_r <= 8'd0;
                        ser_frame <= 1'b1;
                        busy      <= 1'b1;
                        state_r   <= SEND;
                    end else begin
                        ser_out   <= 1'b1;
                        ser_frame <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                    end
                end
                SEND: begin
                    if (bit_end_s) begin
                        div_cnt_r <= 8'd0;
                        if (bit_cnt_r == PAR_BIT) begin
                            ser_out   <= 1'b1;
                            ser_frame <= 1'b0;
                            done      <= 1'b1;
                            state_r   <= DONE;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 6'd1;
                            shift_r   <= shift_r >> 1;
                            if (bit_cnt_r == DATA_LAST) begin
                                ser_out <= parity_r;
                            end else begin
                                ser_out <= shift_r[0];
                            end
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + 8'd1;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    ser_out   <= 1'b1;
                    ser_frame <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
